// File: rtl/noc_credit_rx.sv
// noc_credit_rx: receive end of the NoC credit link; DEPTH-entry flit FIFO drained as an AXI-Stream master.
// Latency: noc_valid -> m_tvalid 1 cycle, pop -> noc_credit 1 cycle (registered, no combinational bypass).
// Backpressure: m_tready low holds the head stable; upstream is throttled only by withheld credits.
module noc_credit_rx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              noc_valid,
  input  logic [DATA_W-1:0] noc_data,
  input  logic              noc_last,
  output logic              noc_credit,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic [CNT_W-1:0]  occupancy,
  output logic [15:0]       pkt_count,
  output logic              err_overflow
);

  localparam int PTR_W = CNT_W - 1;

  logic [DATA_W:0]  mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic             full;
  logic             push_ok;
  logic             pop;

  // A flit arriving while full is dropped even if the head pops this cycle:
  // that slot's credit has not reached the sender yet.
  assign full     = (occupancy == CNT_W'(DEPTH));
  assign push_ok  = noc_valid & ~full;
  assign m_tvalid = (occupancy != '0);
  assign pop      = m_tvalid & m_tready;
  assign m_tdata  = mem[rp][DATA_W-1:0];
  assign m_tlast  = mem[rp][DATA_W];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp] <= {noc_last, noc_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp           <= '0;
      rp           <= '0;
      occupancy    <= '0;
      noc_credit   <= 1'b0;
      pkt_count    <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wp <= wp + PTR_W'(1);
      end
      if (pop) begin
        rp <= rp + PTR_W'(1);
      end
      occupancy  <= occupancy + CNT_W'(push_ok) - CNT_W'(pop);
      noc_credit <= pop;
      if (pop & m_tlast) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (noc_valid & full) begin
        err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/noc_credit_rx.md
# noc_credit_rx

Receive-side endpoint of the NoC credit link: accepts flits pushed by an upstream credit transmitter, buffers them in a DEPTH-entry FIFO, and presents them on an AXI-Stream-style master interface toward the PE. Each flit drained from the FIFO returns exactly one credit upstream, so a compliant sender can never overrun the buffer. It sits between a router output port and the PE-facing AXI Stream logic, complementing the transmit-side credit counter.

## Interface
- DATA_W, 32, flit payload width (mapped to tdata)
- DEPTH, 4, FIFO entries = credits owned by the upstream sender after reset; power of two, ≥2
- CNT_W, $clog2(DEPTH)+1, occupancy width (derived, not overridden)
- clk  in  1  sole clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- noc_valid  in  1  flit present this cycle (no ready; sender only pushes while holding a credit)
- noc_data  in  DATA_W  flit payload
- noc_last  in  1  final flit of packet
- noc_credit  out  1  one-cycle pulse returning one credit upstream
- m_tvalid  out  1  AXI Stream valid toward PE
- m_tready  in  1  AXI Stream ready from PE
- m_tdata  out  DATA_W  payload of FIFO head
- m_tlast  out  1  last flag of FIFO head
- occupancy  out  CNT_W  entries currently stored, 0..DEPTH
- pkt_count  out  16  packets delivered (tlast handshakes), wraps 0xFFFF→0x0000
- err_overflow  out  1  sticky: flit arrived while FIFO full

## Operation
- Storage: DEPTH×(DATA_W+1) array, write pointer wp, read pointer rp, each CNT_W-1 bits, wrap modulo DEPTH; count register occupancy.
- push = noc_valid. pop = m_tvalid & m_tready.
- Accepted push: occupancy<DEPTH at the push cycle → store {noc_last,noc_data} at wp, wp++.
- Overflow: push while occupancy==DEPTH → flit dropped, wp unchanged, err_overflow set; holds even if a pop occurs the same cycle (the credit for that pop has not reached the sender yet, so a compliant sender cannot do this).
- Occupancy next = occupancy + accepted_push − pop; simultaneous accepted push and pop leaves it unchanged.
- m_tvalid = (occupancy != 0); m_tdata/m_tlast driven from entry rp; stable while m_tvalid & !m_tready (AXI-Stream rule).
- pop → rp++, and noc_credit asserted on the following cycle (registered). One pulse per pop; back-to-back pops give back-to-back pulses.
- pkt_count increments on pop with m_tlast=1.
- err_overflow cleared only by reset.
- No initial credit burst: the sender presets its counter to DEPTH on reset.

## Timing
- Reset (rst=0, asynchronous assertion, synchronous-safe release): wp=rp=0, occupancy=0, m_tvalid=0, noc_credit=0, pkt_count=0, err_overflow=0; m_tdata/m_tlast don't-care (storage not reset).
- Latency noc_valid → m_tvalid: 1 cycle (push at edge N visible after edge N, no combinational bypass).
- pop → noc_credit: 1 cycle. Round-trip credit loop with a 1-cycle sender yields ≥DEPTH-limited throughput; DEPTH≥3 sustains 1 flit/cycle.
- Full: occupancy==DEPTH; empty: occupancy==0, m_tvalid=0, pop impossible.
- Pointer wrap: DEPTH-1 → 0 with no bubble.
- Reset mid-packet: all buffered flits discarded, no credits returned for them; sender must also reset.
- No combinational path from m_tready or noc_valid to noc_credit.

## Test plan
- Single flit: reset, noc_valid=1 data=0xDEADBEEF last=1, m_tready=1 → m_tvalid next cycle with 0xDEADBEEF, tlast=1; noc_credit pulses one cycle after handshake; pkt_count=1.
- Fill and stall: DEPTH=4, push 4 flits 0x1..0x4 with m_tready=0 → occupancy=4, no credits; raise m_tready → 0x1..0x4 in order over 4 cycles, 4 consecutive credit pulses, occupancy=0.
- Streaming with wrap: model sender with 4 credits, 20 flits continuous, m_tready=1 → all 20 delivered in order, pointers wrap 5 times, no overflow, 20 credits returned.
- Backpressure stability: m_tready toggles 1010… with full FIFO → m_tdata/m_tlast unchanged while tvalid&!tready; no data loss.
- Overflow: fill 4, push 0x55 with concurrent pop → 0x55 dropped, err_overflow=1 persists; only original 4 flits emerge.
- Async reset mid-stream: drop rst for half a cycle with 3 flits buffered → m_tvalid, occupancy, noc_credit go 0 immediately; no stale flit after release.
